smc_seq: RTL



---
 rtl/smc_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/smc_seq.sv
// rtl/smc_seq.sv - sequenced MOSFET Id/gm calculator: one shared evaluator, insertion sort, weighted result
// Build option SMC_SEQ_ROUND_EN: final divisions round half-up instead of truncating.
module smc_seq #(
  parameter int N_MOS = 6,
  parameter int VAL_W = 8,
  parameter int OUT_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [1:0]         mode,
  input  logic [3*N_MOS-1:0] w_in,
  input  logic [3*N_MOS-1:0] vgs_in,
  input  logic [3*N_MOS-1:0] vds_in,
  output logic               busy,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_n
);
  localparam int CNT_W = (N_MOS > 1) ? $clog2(N_MOS) : 1;
  localparam int SUM_W = VAL_W + 4;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_mode;
  logic [3*N_MOS-1:0] r_w;
  logic [3*N_MOS-1:0] r_vgs;
  logic [3*N_MOS-1:0] r_vds;
  logic [VAL_W-1:0]   r_s [N_MOS];
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_n;

  logic [2:0]         w_tw, w_tg, w_td, w_vov;
  logic [9:0]         w_num;
  logic [VAL_W-1:0]   w_val;
  logic [N_MOS-1:0]   w_ge;
  logic [VAL_W-1:0]   w_ins [N_MOS];
  logic [VAL_W-1:0]   w_n0, w_n1, w_n2;
  logic [SUM_W-1:0]   w_sum;
  logic [OUT_W-1:0]   w_res;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = CALC;
      CALC:    if (r_cnt == CNT_W'(N_MOS - 1)) w_next = OUT;
      OUT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_tw  = r_w[3*r_cnt +: 3];
  assign w_tg  = r_vgs[3*r_cnt +: 3];
  assign w_td  = r_vds[3*r_cnt +: 3];
  assign w_vov = w_tg - 3'd1;

  // Full-width products first; the single divide by 3 is shared by all four cases.
  always_comb begin
    w_num = '0;
    if (w_tg > 3'd1) begin
      if (w_vov > w_td)
        w_num = r_mode[0] ? 10'd2 * 10'(w_tw) * 10'(w_td)
                          : 10'(w_tw) * (10'd2 * 10'(w_vov) * 10'(w_td) - 10'(w_td) * 10'(w_td));
      else
        w_num = r_mode[0] ? 10'd2 * 10'(w_tw) * 10'(w_vov)
                          : 10'(w_tw) * 10'(w_vov) * 10'(w_vov);
    end
  end

  assign w_val = VAL_W'(w_num / 10'd3);

  // Register stays descending; unfilled slots are zero, so w_ge is always a prefix.
  always_comb begin
    for (int j = 0; j < N_MOS; j++) w_ge[j] = (r_s[j] >= w_val);
    w_ins[0] = w_ge[0] ? r_s[0] : w_val;
    for (int j = 1; j < N_MOS; j++) begin
      if (w_ge[j])        w_ins[j] = r_s[j];
      else if (w_ge[j-1]) w_ins[j] = w_val;
      else                w_ins[j] = r_s[j-1];
    end
  end

  assign w_n0 = r_mode[1] ? r_s[0] : r_s[N_MOS-3];
  assign w_n1 = r_mode[1] ? r_s[1] : r_s[N_MOS-2];
  assign w_n2 = r_mode[1] ? r_s[2] : r_s[N_MOS-1];

  always_comb begin
    if (r_mode[0])
      w_sum = SUM_W'(w_n0) + SUM_W'(w_n1) + SUM_W'(w_n2);
    else
      w_sum = SUM_W'(3) * SUM_W'(w_n0) + SUM_W'(4) * SUM_W'(w_n1) + SUM_W'(5) * SUM_W'(w_n2);
`ifdef SMC_SEQ_ROUND_EN
    w_res = r_mode[0] ? OUT_W'((w_sum + SUM_W'(1)) / SUM_W'(3))
                      : OUT_W'((w_sum + SUM_W'(6)) / SUM_W'(12));
`else
    w_res = r_mode[0] ? OUT_W'(w_sum / SUM_W'(3))
                      : OUT_W'(w_sum / SUM_W'(12));
`endif
  end

  // OUT is the final-mix cycle; the registered strobe appears in the cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_mode      <= '0;
      r_w         <= '0;
      r_vgs       <= '0;
      r_vds       <= '0;
      r_out_valid <= 1'b0;
      r_out_n     <= '0;
      for (int j = 0; j < N_MOS; j++) r_s[j] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_n     <= '0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mode <= mode;
            r_w    <= w_in;
            r_vgs  <= vgs_in;
            r_vds  <= vds_in;
            r_cnt  <= '0;
            for (int j = 0; j < N_MOS; j++) r_s[j] <= '0;
          end
        end
        CALC: begin
          for (int j = 0; j < N_MOS; j++) r_s[j] <= w_ins[j];
          r_cnt <= r_cnt + CNT_W'(1);
        end
        OUT: begin
          r_out_valid <= 1'b1;
          r_out_n     <= w_res;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != IDLE) || r_out_valid;
  assign out_valid = r_out_valid;
  assign out_n     = r_out_n;

endmodule
